// File: rtl/cache_ctrl_nway.sv
// N-way set-associative, write-through, no-write-allocate cache controller.
// Sits between the MEM stage (stalled through freeze) and a line-wide
// req/ack memory backend. Tree-PLRU replacement, walking flush, and
// saturating hit/miss counters for loads.
module cache_ctrl_nway #(
  parameter int ADDR_W     = 18,
  parameter int INDEX_W    = 6,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [31:0]              wdata,
  input  logic                     rd_en,
  input  logic                     wr_en,
  output logic [31:0]              rdata,
  output logic                     freeze,
  input  logic                     flush,
  output logic                     flush_busy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                     mem_ack,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  localparam int OFF_W  = 2 + $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_W - OFF_W - INDEX_W;
  localparam int SETS   = 2 ** INDEX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_MISS = 2'd1;
  localparam logic [1:0] ST_WR_MEM  = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [INDEX_W-1:0] IDX_ONE  = {{(INDEX_W-1){1'b0}}, 1'b1};
  localparam logic [INDEX_W-1:0] IDX_LAST = {INDEX_W{1'b1}};

  // Victim way encoded by the PLRU tree. Bits are zero-extended to the
  // 4-way layout: bit0 = root (0 -> left pair), bit1 = ways 0/1, bit2 = ways 2/3.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
    logic [2:0] pp;
    logic [1:0] v;
    pp = 3'b000;
    pp[PLRU_W-1:0] = p;
    if (WAYS == 4) begin
      v = pp[0] ? {1'b1, pp[2]} : {1'b0, pp[1]};
    end else if (WAYS == 2) begin
      v = {1'b0, pp[0]};
    end else begin
      v = 2'b00;
    end
    return v[WAY_W-1:0];
  endfunction

  // New PLRU bits after touching way w: every node on its path points away.
  function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0] p,
                                                    input logic [WAY_W-1:0]  w);
    logic [2:0] pp;
    logic [1:0] ww;
    pp = 3'b000;
    pp[PLRU_W-1:0] = p;
    ww = 2'b00;
    ww[WAY_W-1:0] = w;
    if (WAYS == 4) begin
      pp[0] = ~ww[1];
      if (ww[1]) begin
        pp[2] = ~ww[0];
      end else begin
        pp[1] = ~ww[0];
      end
    end else if (WAYS == 2) begin
      pp[0] = ~ww[0];
    end else begin
      pp = 3'b000;
    end
    return pp[PLRU_W-1:0];
  endfunction

  logic [1:0]         state;
  logic [INDEX_W-1:0] flush_ptr;
  logic               st_done;

  logic [SETS-1:0]    valid_q [WAYS];
  logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
  logic [31:0]        data_q  [WAYS][SETS][LINE_WORDS];
  logic [PLRU_W-1:0]  plru_q  [SETS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WSEL_W-1:0]  word_sel;
  logic [WAYS-1:0]    hit_vec;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim;
  logic [31:0]        rd_word;
  logic               fill_en;
  logic               st_wr_en;
  logic               unused_addr;

  assign idx = addr[OFF_W+INDEX_W-1:OFF_W];
  assign tag = addr[ADDR_W-1:OFF_W+INDEX_W];
  assign unused_addr = ^addr[1:0];

  generate
    if (LINE_WORDS > 1) begin : g_wsel
      assign word_sel = addr[OFF_W-1:2];
    end else begin : g_wsel1
      assign word_sel = 1'b0;
    end
  endgenerate

  // Tag lookup across all ways of the addressed set.
  always_comb begin
    hit_vec = {WAYS{1'b0}};
    hit_way = {WAY_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
      hit_way    = hit_way | (hit_vec[w] ? WAY_W'(w) : {WAY_W{1'b0}});
    end
    hit     = |hit_vec;
    rd_word = data_q[hit_way][idx][word_sel];
  end

  // Fill victim: lowest-index invalid way wins over the PLRU choice.
  always_comb begin
    victim = plru_victim(plru_q[idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      victim = valid_q[w][idx] ? victim : WAY_W'(w);
    end
  end

  // Stall the MEM stage while its request cannot complete this cycle.
  always_comb begin
    if (rd_en || wr_en) begin
      if (state != ST_IDLE) begin
        freeze = 1'b1;
      end else if (flush) begin
        freeze = 1'b1;
      end else if (rd_en) begin
        freeze = ~hit;
      end else begin
        freeze = ~st_done;
      end
    end else begin
      freeze = 1'b0;
    end
  end

  // Load data is only presented when the load actually retires.
  always_comb begin
    if (rd_en && !freeze) begin
      rdata = rd_word;
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Array write strobes: line fill on read ack, word update on store hit.
  always_comb begin
    fill_en  = !rst && (state == ST_RD_MISS) && mem_ack;
    st_wr_en = !rst && (state == ST_IDLE) && !flush && !rd_en && wr_en && !st_done && hit;
  end

  // Tag and data arrays; contents are qualified by valid so need no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[victim][idx] <= tag;
      for (int k = 0; k < LINE_WORDS; k++) begin
        data_q[victim][idx][k] <= mem_rdata[32*k +: 32];
      end
    end else if (st_wr_en) begin
      data_q[hit_way][idx][word_sel] <= wdata;
    end
  end

  // Controller FSM, valid/PLRU state, backend port and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_ptr  <= {INDEX_W{1'b0}};
      flush_busy <= 1'b0;
      st_done    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= 32'h0000_0000;
      hit_cnt    <= {CNT_W{1'b0}};
      miss_cnt   <= {CNT_W{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= {SETS{1'b0}};
      end
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= {PLRU_W{1'b0}};
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state      <= ST_FLUSH;
            flush_ptr  <= {INDEX_W{1'b0}};
            flush_busy <= 1'b1;
          end else if (rd_en) begin
            st_done <= 1'b0;
            if (hit) begin
              if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_ONE;
              plru_q[idx] <= plru_update(plru_q[idx], hit_way);
            end else begin
              if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_ONE;
              state    <= ST_RD_MISS;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
          end else if (wr_en && !st_done) begin
            // Word write into the cache (if present) happens once, here.
            if (hit) plru_q[idx] <= plru_update(plru_q[idx], hit_way);
            state     <= ST_WR_MEM;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata;
          end else begin
            // Completed store retires this cycle; forget it.
            st_done <= 1'b0;
          end
        end
        ST_RD_MISS: begin
          if (mem_ack) begin
            valid_q[victim][idx] <= 1'b1;
            plru_q[idx]          <= plru_update(plru_q[idx], victim);
            mem_req              <= 1'b0;
            state                <= ST_IDLE;
          end
        end
        ST_WR_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            st_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[w][flush_ptr] <= 1'b0;
          end
          plru_q[flush_ptr] <= {PLRU_W{1'b0}};
          flush_ptr         <= flush_ptr + IDX_ONE;
          if (flush_ptr == IDX_LAST) begin
            state      <= ST_IDLE;
            flush_busy <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
